// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU state encoding and IEEE-754 single-precision constants
package fpu_pkg;
  typedef enum logic [1:0] {WAIT_ST, UNPACK, DIV, FIN} state_e;
  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
endpackage

// File: rtl/fnorm_unpack.sv
// fnorm_unpack: splits a single-precision operand into a normalised 24-bit mantissa, signed effective exponent and zero flag
module fnorm_unpack
  import fpu_pkg::*;
(
  input  logic [31:0]       op_i,
  output logic [23:0]       mant_o,
  output logic signed [9:0] exp_o,
  output logic              zero_o
);
  logic [22:0] frac;
  logic [7:0]  expf;
  logic [4:0]  k;
  logic [23:0] norm_m;
  assign frac = op_i[22:0];
  assign expf = op_i[30:23];
  // k counts zeros above the leading one; the highest set bit wins
  always_comb begin
    k = '0;
    for (int i = 0; i < 23; i++) if (frac[i]) k = 5'(22 - i);
  end
  assign norm_m = {1'b0, frac} << (k + 5'd1);
  assign mant_o = (expf != 8'd0) ? {1'b1, frac} : norm_m;
  assign exp_o  = (expf != 8'd0) ? $signed({2'b0, expf}) : -$signed({5'b0, k});
  assign zero_o = (expf == 8'd0) && (frac == 23'd0);
endmodule

// File: rtl/fdiv.sv
// fdiv: iterative restoring single-precision divider, truncating, flush-to-zero on underflow
module fdiv
  import fpu_pkg::*;
#(
  parameter int ITER = 25
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [31:0] adata,
  input  logic [31:0] bdata,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);
  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d, result_q, result_d;
  logic               s_q, s_d, az_q, az_d, bz_q, bz_d, done_q, done_d, busy_q, busy_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        mb_q, mb_d;
  logic [25:0]        r_q, r_d, r_sub;
  logic [24:0]        q_q, q_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [23:0]        ma, mb;
  logic signed [9:0]  ea, eb, e_r;
  logic               za, zb, ge;
  logic [22:0]        mant;
  logic [31:0]        res;
  fnorm_unpack u_ua (.op_i(a_q), .mant_o(ma), .exp_o(ea), .zero_o(za));
  fnorm_unpack u_ub (.op_i(b_q), .mant_o(mb), .exp_o(eb), .zero_o(zb));
  assign ge    = r_q >= {2'b0, mb_q};
  assign r_sub = ge ? r_q - {2'b0, mb_q} : r_q;
  assign e_r   = q_q[24] ? exp_q : exp_q - 10'sd1;
  assign mant  = q_q[24] ? q_q[23:1] : q_q[22:0];
  assign res   = (az_q && bz_q)   ? QNAN :
                 bz_q             ? {s_q, EXP_MAX, 23'b0} :
                 az_q             ? 32'b0 :
                 (e_r <= 10'sd0)  ? 32'b0 :
                 (e_r >= 10'sd255) ? {s_q, EXP_MAX, 23'b0} :
                 {s_q, e_r[7:0], mant};
  // control sequencing and datapath next-state
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    az_d     = az_q;
    bz_d     = bz_q;
    exp_d    = exp_q;
    mb_d     = mb_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    busy_d   = busy_q;
    case (state_q)
      WAIT_ST: begin
        done_d = 1'b0;
        if (en) begin
          a_d     = adata;
          b_d     = bdata;
          busy_d  = 1'b1;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        s_d     = a_q[31] ^ b_q[31];
        az_d    = za;
        bz_d    = zb;
        exp_d   = ea - eb + $signed(10'(BIAS));
        mb_d    = mb;
        r_d     = {2'b0, ma};
        q_d     = '0;
        cnt_d   = 5'(ITER - 1);
        state_d = DIV;
      end
      DIV: begin
        q_d[cnt_q] = ge;
        r_d        = r_sub << 1;
        cnt_d      = cnt_q - 5'd1;
        state_d    = (cnt_q == 5'd0) ? FIN : DIV;
      end
      default: begin
        result_d = res;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = WAIT_ST;
      end
    endcase
  end
  // state and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= WAIT_ST;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= 1'b0;
      az_q     <= 1'b0;
      bz_q     <= 1'b0;
      exp_q    <= '0;
      mb_q     <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      az_q     <= az_d;
      bz_q     <= bz_d;
      exp_q    <= exp_d;
      mb_q     <= mb_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end
  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_fdiv.sv
// tb_fdiv: directed scoreboard bench for the iterative floating-point divider
module tb_fdiv;
  logic        clk = 1'b0, rstn = 1'b0, en = 1'b0;
  logic [31:0] adata = '0, bdata = '0;
  logic [31:0] result;
  logic        done, busy;
  int          checks = 0, errors = 0, dones = 0, d0;
  logic [31:0] sb[$];
  logic [31:0] exp_v, last_exp = '0;
  logic        done_prev = 1'b0;

  fdiv dut (.clk(clk), .rstn(rstn), .en(en), .adata(adata), .bdata(bdata),
            .result(result), .done(done), .busy(busy));

  always #5 clk = ~clk;

  // scoreboard: every done pulse pops one expected result
  always @(negedge clk) begin
    if (done) begin
      dones++;
      checks++;
      assert (!done_prev) else begin errors++; $error("FAIL done_width done high two cycles"); end
      checks++;
      assert (sb.size() > 0) else begin errors++; $error("FAIL spurious_done result=%h expected none", result); end
      if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        checks++;
        assert (result === exp_v) else begin errors++; $error("FAIL result got %h expected %h", result, exp_v); end
      end
    end
    done_prev = done;
  end

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r, input bit poke);
    int n;
    @(negedge clk);
    adata = a; bdata = b; en = 1'b1;
    sb.push_back(r);
    @(negedge clk);
    en = 1'b0;
    n = 0;
    checks++;
    assert (busy === 1'b1) else begin errors++; $error("FAIL busy_start got %b expected 1", busy); end
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (poke && n == 5) begin en = 1'b1; adata = 32'h3F800000; bdata = 32'h40400000; end
      if (poke && n == 6) en = 1'b0;
      if (poke && n == 10) begin
        checks++;
        assert (result === last_exp) else begin errors++; $error("FAIL result_hold got %h expected %h", result, last_exp); end
      end
      if (n == 26) begin
        checks++;
        assert (busy === 1'b1) else begin errors++; $error("FAIL busy_26 got %b expected 1", busy); end
      end
    end
    checks++;
    assert (n == 27) else begin errors++; $error("FAIL latency got %0d expected 27", n); end
    checks++;
    assert (busy === 1'b0) else begin errors++; $error("FAIL busy_end got %b expected 0", busy); end
    @(negedge clk);
    checks++;
    assert (done === 1'b0) else begin errors++; $error("FAIL done_drop got %b expected 0", done); end
    last_exp = r;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    assert (result === 32'h0 && busy === 1'b0 && done === 1'b0)
      else begin errors++; $error("FAIL reset_state got %h/%b/%b expected 0/0/0", result, busy, done); end
    rstn = 1'b1;
    op(32'h40C00000, 32'h40000000, 32'h40400000, 0);
    op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0);
    op(32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 0);
    op(32'hBF800000, 32'h00000000, 32'hFF800000, 0);
    op(32'h00000000, 32'h00000000, 32'h7FC00000, 0);
    op(32'h00000000, 32'h40A00000, 32'h00000000, 0);
    op(32'h00400000, 32'h3F000000, 32'h00800000, 0);
    op(32'h7F000000, 32'h00800000, 32'h7F800000, 0);
    op(32'h00800000, 32'h40000000, 32'h00000000, 0);
    op(32'h40C00000, 32'h40000000, 32'h40400000, 1);
    // en held high: second operation accepted in the first done cycle
    @(negedge clk);
    adata = 32'h40C00000; bdata = 32'h40000000; en = 1'b1;
    sb.push_back(32'h40400000);
    sb.push_back(32'h3EAAAAAA);
    d0 = dones;
    @(negedge clk);
    adata = 32'h3F800000; bdata = 32'h40400000;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 39) en = 1'b0;
      if (i == 27 || i == 55) begin
        checks++;
        assert (done === 1'b1) else begin errors++; $error("FAIL held_done_%0d got %b expected 1", i, done); end
      end
    end
    checks++;
    assert (dones - d0 == 2) else begin errors++; $error("FAIL held_count got %0d expected 2", dones - d0); end
    // reset mid-operation aborts with no done
    @(negedge clk);
    adata = 32'h40C00000; bdata = 32'h40000000; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    assert (result === 32'h0) else begin errors++; $error("FAIL rst_result got %h expected 0", result); end
    checks++;
    assert (busy === 1'b0) else begin errors++; $error("FAIL rst_busy got %b expected 0", busy); end
    checks++;
    assert (done === 1'b0) else begin errors++; $error("FAIL rst_done got %b expected 0", done); end
    rstn = 1'b1;
    d0 = dones;
    repeat (40) @(negedge clk);
    checks++;
    assert (dones == d0) else begin errors++; $error("FAIL rst_nodone got %0d expected %0d", dones, d0); end
    last_exp = 32'h0;
    op(32'h40C00000, 32'h40000000, 32'h40400000, 0);
    checks++;
    assert (sb.size() == 0) else begin errors++; $error("FAIL sb_left got %0d expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
